// File: rtl/mc_maindec_pkg.sv
// mc_ctrl_pkg: shared state, opcode and select encodings for the multicycle MIPS controller
package mc_ctrl_pkg;

    // State encodings are fixed because they are exported on the debug port
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } statetype;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full control word driven into the datapath each cycle
    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       bne;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/mc_maindec_if.sv
// mc_maindec_if: opcode in, control word and debug state out of the main decoder
interface mc_maindec_if #(parameter int STATE_W = 4);

    logic [5:0]         op;
    logic               pcwrite;
    logic               branch;
    logic               bne;
    logic               irwrite;
    logic               memwrite;
    logic               regwrite;
    logic               iord;
    logic               memtoreg;
    logic               regdst;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         pcsrc;
    logic [1:0]         aluop;
    logic [STATE_W-1:0] state;

    // Datapath side: supplies the opcode, consumes the control word
    modport master (
        output op,
        input  pcwrite, branch, bne, irwrite, memwrite, regwrite, iord,
               memtoreg, regdst, alusrca, alusrcb, pcsrc, aluop, state
    );

    // Controller side
    modport slave (
        input  op,
        output pcwrite, branch, bne, irwrite, memwrite, regwrite, iord,
               memtoreg, regdst, alusrca, alusrcb, pcsrc, aluop, state
    );

endinterface

// File: rtl/mc_maindec_outdec.sv
// mc_ctrl_outdec: Moore output decode, control word as a pure function of state
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  statetype state_i,
    output ctrl_t    ctrl_o
);

    // Unlisted fields and unused encodings stay at zero
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.irwrite = 1'b1;
                ctrl_o.pcwrite = 1'b1;
                ctrl_o.alusrcb = SRCB_FOUR;
            end
            DECODE: ctrl_o.alusrcb = SRCB_IMMSH;
            MEMADR: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
            end
            MEMRD: ctrl_o.iord = 1'b1;
            MEMWB: begin
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.memwrite = 1'b1;
            end
            RTYPEEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            BEQEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.pcsrc   = PCSRC_ALUOUT;
                ctrl_o.branch  = 1'b1;
            end
            BNEEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.pcsrc   = PCSRC_ALUOUT;
                ctrl_o.bne     = 1'b1;
            end
            ADDIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
            end
            ADDIWB: ctrl_o.regwrite = 1'b1;
            JEX: begin
                ctrl_o.pcsrc   = PCSRC_JUMP;
                ctrl_o.pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_maindec.sv
// mc_maindec: multicycle MIPS main control FSM, state register plus next-state logic
module mc_maindec
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input logic          clk,
    input logic          reset,
    mc_maindec_if.slave  bus
);

    statetype state_q;
    ctrl_t    ctrl;

    // Op is only consulted in DECODE and MEMADR; every terminal state returns to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else begin
            case (state_q)
                FETCH: state_q <= DECODE;
                DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: state_q <= MEMADR;
                        OP_RTYPE:     state_q <= RTYPEEX;
                        OP_BEQ:       state_q <= BEQEX;
                        OP_BNE:       state_q <= BNEEX;
                        OP_ADDI:      state_q <= ADDIEX;
                        OP_J:         state_q <= JEX;
                        default:      state_q <= FETCH;
                    endcase
                end
                MEMADR:  state_q <= bus.op == OP_LW ? MEMRD : bus.op == OP_SW ? MEMWR : FETCH;
                MEMRD:   state_q <= MEMWB;
                RTYPEEX: state_q <= RTYPEWB;
                ADDIEX:  state_q <= ADDIWB;
                default: state_q <= FETCH;
            endcase
        end
    end

    mc_ctrl_outdec u_outdec (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    assign bus.pcwrite  = ctrl.pcwrite;
    assign bus.branch   = ctrl.branch;
    assign bus.bne      = ctrl.bne;
    assign bus.irwrite  = ctrl.irwrite;
    assign bus.memwrite = ctrl.memwrite;
    assign bus.regwrite = ctrl.regwrite;
    assign bus.iord     = ctrl.iord;
    assign bus.memtoreg = ctrl.memtoreg;
    assign bus.regdst   = ctrl.regdst;
    assign bus.alusrca  = ctrl.alusrca;
    assign bus.alusrcb  = ctrl.alusrcb;
    assign bus.pcsrc    = ctrl.pcsrc;
    assign bus.aluop    = ctrl.aluop;
    assign bus.state    = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec: directed scoreboard bench for the multicycle main decoder
module tb_mc_maindec;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] cw;
    } exp_t;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    mc_maindec_if #(.STATE_W(4)) bus ();

    mc_maindec #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word per state, packed in a fixed bench-side order
    function automatic logic [15:0] exp_cw(input logic [3:0] st);
        logic pw, br, bn, ir, mw, rw, io, mr, rd, sa;
        logic [1:0] sb, ps, ao;
        {pw, br, bn, ir, mw, rw, io, mr, rd, sa} = '0;
        sb = 2'b00;
        ps = 2'b00;
        ao = 2'b00;
        case (st)
            4'd0:  begin ir = 1; pw = 1; sb = 2'b01; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  io = 1;
            4'd4:  begin mr = 1; rw = 1; end
            4'd5:  begin io = 1; mw = 1; end
            4'd6:  begin sa = 1; ao = 2'b10; end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
            4'd9:  begin sa = 1; sb = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin ps = 2'b10; pw = 1; end
            4'd12: begin sa = 1; ao = 2'b01; ps = 2'b01; bn = 1; end
            default: ;
        endcase
        return {pw, br, bn, ir, mw, rw, io, mr, rd, sa, sb, ps, ao};
    endfunction

    function automatic logic [15:0] obs_cw();
        return {bus.pcwrite, bus.branch, bus.bne, bus.irwrite, bus.memwrite, bus.regwrite,
                bus.iord, bus.memtoreg, bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.aluop};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input exp_t e);
        chk("state", {12'd0, bus.state}, {12'd0, e.st});
        chk("ctrl", obs_cw(), e.cw);
        chk("exclusive", {14'd0, bus.branch & bus.bne, bus.regwrite & bus.memwrite}, 16'd0);
    endtask

    // Drive o from FETCH, switch to o2 after the second sampled state, expect n states (low nibble first)
    task automatic run(input logic [5:0] o, input logic [5:0] o2, input int n, input logic [19:0] seq);
        bus.op = o;
        for (int i = 0; i < n; i++) q.push_back('{st: seq[4*i +: 4], cw: exp_cw(seq[4*i +: 4])});
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_cycle(q.pop_front());
            if (i == 1) bus.op = o2;
        end
    endtask

    initial begin
        reset  = 1'b1;
        bus.op = 6'b100011;
        #21;
        chk_cycle('{st: 4'd0, cw: exp_cw(4'd0)});
        #1 reset = 1'b0;
        run(6'b100011, 6'b100011, 5, 20'h04321);
        run(6'b101011, 6'b101011, 4, 20'h00521);
        run(6'b000000, 6'b000000, 4, 20'h00761);
        run(6'b001000, 6'b001000, 4, 20'h00A91);
        run(6'b000100, 6'b000100, 3, 20'h00081);
        run(6'b000101, 6'b000101, 3, 20'h000C1);
        run(6'b000010, 6'b000010, 3, 20'h000B1);
        run(6'b111111, 6'b111111, 2, 20'h00001);
        run(6'b100011, 6'b000000, 3, 20'h00021);
        run(6'b000000, 6'b100011, 4, 20'h00761);
        run(6'b101011, 6'b101011, 3, 20'h00521);
        #2 reset = 1'b1;
        #1;
        chk_cycle('{st: 4'd0, cw: exp_cw(4'd0)});
        chk("async_memwrite", {15'd0, bus.memwrite}, 16'd0);
        @(negedge clk);
        chk_cycle('{st: 4'd0, cw: exp_cw(4'd0)});
        #1 reset = 1'b0;
        run(6'b100011, 6'b100011, 5, 20'h04321);
        chk("scoreboard_empty", 16'(q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_maindec.md
Name: mc_maindec

Overview:
Main control FSM of the multicycle MIPS processor. Sits between the instruction register (consumes op = instr[31:26]) and the multicycle datapath/aludec (drives enables, mux selects, ALUOp). Exports its state for the top-level debug port. Supports lw, sw, R-type, beq, bne, addi, j.

Parameters:
STATE_W, 4, width of state register and state debug output.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op  in  6  opcode field of the instruction register
pcwrite  out  1  unconditional PC write
branch  out  1  PC write if ALU zero (beq)
bne  out  1  PC write if ALU not zero (bne)
irwrite  out  1  instruction register load
memwrite  out  1  data memory write
regwrite  out  1  register file write
iord  out  1  memory address select: 0=PC, 1=ALUOut
memtoreg  out  1  writeback select: 0=ALUOut, 1=Data
regdst  out  1  destination register: 0=rt, 1=rd
alusrca  out  1  ALU A: 0=PC, 1=A register
alusrcb  out  2  ALU B: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
pcsrc  out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
aluop  out  2  to aludec: 00=add, 01=sub, 10=funct
state  out  STATE_W  current state encoding (debug)

Behaviour:
- Moore FSM; all outputs combinational from state only; op sampled only in DECODE and MEMADR.
- State encodings (fixed): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12.
- Reset: asynchronous; state forced to FETCH immediately on reset high; held while reset high. Outputs during reset = FETCH values (irwrite=1, pcwrite=1, alusrcb=01, all other outputs 0); datapath registers are in reset, so harmless.
- Transitions: FETCH->DECODE. DECODE: lw/sw (100011/101011)->MEMADR, R-type (000000)->RTYPEEX, beq (000100)->BEQEX, bne (000101)->BNEEX, addi (001000)->ADDIEX, j (000010)->JEX, any other opcode->FETCH (treated as NOP). MEMADR: lw->MEMRD, sw->MEMWR, other->FETCH. MEMRD->MEMWB. RTYPEEX->RTYPEWB. ADDIEX->ADDIWB. MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, BNEEX, JEX->FETCH. Encodings 13-15->FETCH next cycle, all outputs 0 while there.
- Outputs per state (unlisted = 0): FETCH irwrite, pcwrite, alusrcb=01. DECODE alusrcb=11. MEMADR alusrca, alusrcb=10. MEMRD iord. MEMWB memtoreg, regwrite. MEMWR iord, memwrite. RTYPEEX alusrca, aluop=10. RTYPEWB regdst, regwrite. BEQEX alusrca, aluop=01, pcsrc=01, branch. BNEEX alusrca, aluop=01, pcsrc=01, bne. ADDIEX alusrca, alusrcb=10. ADDIWB regwrite. JEX pcsrc=10, pcwrite.
- Instruction latency in cycles (FETCH to FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, bne 3, j 3, illegal 2.
- memwrite asserted exactly one cycle per sw; never for any other opcode.
- branch and bne mutually exclusive; regwrite and memwrite never together.

Decomposition:
- Package mc_ctrl_pkg: statetype enum (13 states, 4-bit, encodings above), opcode constants (OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J), ALUOp constants, alusrcb/pcsrc select constants.
- One sub-module: mc_ctrl_outdec, purely combinational state->control-word decoder; mc_maindec holds state register and next-state logic.

Test Plan:
- reset high 22 ns then low, op=100011 held -> state sequence 0,1,2,3,4,0; memwrite=0 throughout; regwrite=1 and memtoreg=1 only in state 4.
- op=101011 -> states 0,1,2,5,0; memwrite=1 and iord=1 exactly one cycle (state 5).
- op=000000 then 001000 -> 0,1,6,7,0 (aluop=10 in 6, regdst=1 in 7) then 0,1,9,10,0 (alusrcb=10 in 9, regdst=0 in 10).
- op=000100, 000101, 000010 -> 0,1,8,0 (branch=1, pcsrc=01, aluop=01); 0,1,12,0 (bne=1, branch=0); 0,1,11,0 (pcwrite=1, pcsrc=10).
- op=111111 -> 0,1,0; no write enable other than FETCH's irwrite/pcwrite ever asserted.
- reset asserted asynchronously mid-MEMWR (between clock edges) -> state=0 and memwrite=0 within same cycle before next edge; after release, fetch restarts from state 0.
